// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave
//  Brief    : Oversampled SPI slave with CKP/CPH modes and back-to-back words.
//  Revision : 1.0  initial release
// ============================================================================
module spi_slave #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ckp_i,
  input  logic             cph_i,
  input  logic             sck_i,
  input  logic             ss_i,
  input  logic             mosi_i,
  input  logic [WIDTH-1:0] tx_data_i,
  output logic             miso_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic             sck_meta_q;
  logic             sck_sync_q;
  logic             sck_prev_q;
  logic             ss_meta_q;
  logic             ss_sync_q;
  logic             ss_prev_q;
  logic             mosi_meta_q;
  logic             mosi_sync_q;
  logic [1:0]       flush_q;
  logic             armed_q;
  logic             armed_d;

  logic [0:0]       state_q;
  logic [0:0]       state_d;

  logic             ckp_q;
  logic             ckp_d;
  logic             cph_q;
  logic             cph_d;
  logic [WIDTH-1:0] tx_shift_q;
  logic [WIDTH-1:0] tx_shift_d;
  logic [WIDTH-1:0] rx_shift_q;
  logic [WIDTH-1:0] rx_shift_d;
  logic [WIDTH-1:0] rx_data_q;
  logic [WIDTH-1:0] rx_data_d;
  logic             rx_valid_q;
  logic             rx_valid_d;
  logic             miso_q;
  logic             miso_d;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] bit_cnt_d;

  logic             sck_rise;
  logic             sck_fall;
  logic             lead_edge;
  logic             trail_edge;
  logic             shift_edge;
  logic             sample_edge;
  logic             ss_fall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      ss_meta_q   <= 1'b1;
      ss_sync_q   <= 1'b1;
      ss_prev_q   <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      flush_q     <= 2'b00;
      armed_q     <= 1'b0;
    end else begin
      sck_meta_q  <= sck_i;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      ss_meta_q   <= ss_i;
      ss_sync_q   <= ss_meta_q;
      ss_prev_q   <= ss_sync_q;
      mosi_meta_q <= mosi_i;
      mosi_sync_q <= mosi_meta_q;
      flush_q     <= {flush_q[0], 1'b1};
      armed_q     <= armed_d;
    end
  end

  // The SS chain resets high, so a select held low through reset would look
  // like a falling edge; only arm once a genuine high level has been seen.
  always_comb begin
    armed_d = armed_q | (flush_q[1] & ss_sync_q);
  end

  assign sck_rise    = sck_sync_q & ~sck_prev_q;
  assign sck_fall    = ~sck_sync_q & sck_prev_q;
  assign lead_edge   = ckp_q ? sck_fall : sck_rise;
  assign trail_edge  = ckp_q ? sck_rise : sck_fall;
  assign shift_edge  = cph_q ? lead_edge : trail_edge;
  assign sample_edge = cph_q ? trail_edge : lead_edge;
  assign ss_fall     = armed_q & ss_prev_q & ~ss_sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (ss_fall)   state_d = ST_ACTIVE;
      ST_ACTIVE: if (ss_sync_q) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == ST_ACTIVE);
  end

  always_comb begin
    ckp_d      = ckp_q;
    cph_d      = cph_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    miso_d     = miso_q;
    bit_cnt_d  = bit_cnt_q;

    if (state_q == ST_IDLE) begin
      miso_d     = 1'b0;
      bit_cnt_d  = '0;
      rx_shift_d = '0;
      if (ss_fall) begin
        ckp_d = ckp_i;
        cph_d = cph_i;
        // CPH=0 drives the MSB before the first edge; CPH=1 waits for it.
        if (cph_i) begin
          tx_shift_d = tx_data_i;
        end else begin
          miso_d     = tx_data_i[WIDTH-1];
          tx_shift_d = {tx_data_i[WIDTH-2:0], 1'b0};
        end
      end
    end else if (ss_sync_q) begin
      miso_d     = 1'b0;
      bit_cnt_d  = '0;
      rx_shift_d = '0;
    end else begin
      if (shift_edge) begin
        miso_d     = tx_shift_q[WIDTH-1];
        tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
      end
      if (sample_edge) begin
        rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_sync_q};
        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          rx_data_d  = {rx_shift_q[WIDTH-2:0], mosi_sync_q};
          rx_valid_d = 1'b1;
          bit_cnt_d  = '0;
          // Next shift edge emits the MSB of the freshly loaded word.
          tx_shift_d = tx_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ckp_q      <= 1'b0;
      cph_q      <= 1'b0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      bit_cnt_q  <= '0;
    end else begin
      ckp_q      <= ckp_d;
      cph_q      <= cph_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign miso_o     = miso_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave
//  Brief    : Self-checking bench for spi_slave with an RX word scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_slave;

  localparam int HALF = 8;

  logic       clk_i;
  logic       rst_ni;
  logic       ckp_i;
  logic       cph_i;
  logic       sck_i;
  logic       ss_i;
  logic       mosi_i;
  logic [7:0] tx_data_i;
  logic       miso_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       busy_o;

  int         checks = 0;
  int         errors = 0;
  int         rx_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rx = 8'h00;
  logic       cur_ckp = 1'b0;
  logic       cur_cph = 1'b0;

  spi_slave #(.WIDTH(8)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .ckp_i      (ckp_i),
    .cph_i      (cph_i),
    .sck_i      (sck_i),
    .ss_i       (ss_i),
    .mosi_i     (mosi_i),
    .tx_data_i  (tx_data_i),
    .miso_o     (miso_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .busy_o     (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Scoreboard: every RX_VALID cycle consumes exactly one expected word.
  always @(negedge clk_i) begin
    if (rst_ni && rx_valid_o) begin
      rx_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected: rx_valid with rx_data=%h, none expected", rx_data_o);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rx_data_o !== e) begin
          errors++;
          $display("FAIL rx_word: got %h expected %h", rx_data_o, e);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic ss_begin(input logic ckp, input logic cph, input logic [7:0] tx);
    cur_ckp   = ckp;
    cur_cph   = cph;
    ckp_i     = ckp;
    cph_i     = cph;
    sck_i     = ckp;
    ss_i      = 1'b1;
    tx_data_i = tx;
    clks(HALF);
    ss_i = 1'b0;
    clks(HALF);
  endtask

  task automatic ss_end();
    clks(HALF);
    ss_i = 1'b1;
    clks(HALF);
  endtask

  // Master side: drives MOSI, samples MISO at its own sampling edge.
  task automatic shift_word(input logic [7:0] mosi_w, input logic [7:0] exp_miso,
                            input int nbits, input string tag);
    logic [7:0] got;
    got = 8'h00;
    if (nbits == 8) begin
      exp_q.push_back(mosi_w);
      last_rx = mosi_w;
    end
    for (int i = 0; i < nbits; i++) begin
      if (!cur_cph) begin
        mosi_i = mosi_w[7-i];
        clks(HALF);
        got[7-i] = miso_o;
        sck_i = ~cur_ckp;
        clks(HALF);
        sck_i = cur_ckp;
      end else begin
        clks(HALF);
        sck_i  = ~cur_ckp;
        mosi_i = mosi_w[7-i];
        clks(HALF);
        got[7-i] = miso_o;
        sck_i = cur_ckp;
      end
    end
    if (nbits == 8) begin
      checks++;
      if (got !== exp_miso) begin
        errors++;
        $display("FAIL %s miso_word: got %h expected %h", tag, got, exp_miso);
      end
    end
  endtask

  task automatic test_reset();
    rst_ni    = 1'b0;
    ckp_i     = 1'b0;
    cph_i     = 1'b0;
    sck_i     = 1'b0;
    ss_i      = 1'b1;
    mosi_i    = 1'b0;
    tx_data_i = 8'h00;
    #25;
    checks += 4;
    if (miso_o !== 1'b0)     begin errors++; $display("FAIL reset_miso: got %b expected 0", miso_o); end
    if (rx_data_o !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data_o); end
    if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid_o); end
    if (busy_o !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    clks(4);
  endtask

  task automatic test_mode00();
    int n0;
    n0 = rx_cnt;
    ss_begin(1'b0, 1'b0, 8'hA5);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL m00_busy: got %b expected 1", busy_o); end
    shift_word(8'h3C, 8'hA5, 8, "m00");
    ss_end();
    checks += 3;
    if (rx_data_o !== 8'h3C) begin errors++; $display("FAIL m00_rx_data: got %h expected 3c", rx_data_o); end
    if (rx_cnt - n0 != 1)    begin errors++; $display("FAIL m00_pulses: got %0d expected 1", rx_cnt - n0); end
    if (miso_o !== 1'b0)     begin errors++; $display("FAIL m00_idle_miso: got %b expected 0", miso_o); end
  endtask

  task automatic test_mode11();
    int n0;
    n0 = rx_cnt;
    ss_begin(1'b1, 1'b1, 8'h5A);
    shift_word(8'hC3, 8'h5A, 8, "m11");
    ss_end();
    checks += 2;
    if (rx_data_o !== 8'hC3) begin errors++; $display("FAIL m11_rx_data: got %h expected c3", rx_data_o); end
    if (rx_cnt - n0 != 1)    begin errors++; $display("FAIL m11_pulses: got %0d expected 1", rx_cnt - n0); end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = rx_cnt;
    ss_begin(1'b0, 1'b1, 8'hF0);
    tx_data_i = 8'h0F;
    shift_word(8'h12, 8'hF0, 8, "b2b_w0");
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_busy_mid: got %b expected 1", busy_o); end
    shift_word(8'h34, 8'h0F, 8, "b2b_w1");
    ss_end();
    checks += 3;
    if (rx_data_o !== 8'h34)  begin errors++; $display("FAIL b2b_rx_data: got %h expected 34", rx_data_o); end
    if (rx_cnt - n0 != 2)     begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", rx_cnt - n0); end
    if (exp_q.size() != 0)    begin errors++; $display("FAIL b2b_pending: got %0d words left expected 0", exp_q.size()); end
  endtask

  task automatic test_abort();
    int n0;
    n0 = rx_cnt;
    ss_begin(1'b1, 1'b0, 8'h77);
    shift_word(8'hE7, 8'h77, 5, "abort");
    ss_i = 1'b1;
    clks(3);
    checks += 3;
    if (busy_o !== 1'b0)       begin errors++; $display("FAIL abort_busy: got %b expected 0", busy_o); end
    if (rx_data_o !== last_rx) begin errors++; $display("FAIL abort_rx_data: got %h expected %h", rx_data_o, last_rx); end
    clks(HALF);
    if (rx_cnt != n0)          begin errors++; $display("FAIL abort_pulses: got %0d expected 0", rx_cnt - n0); end
    ss_begin(1'b1, 1'b0, 8'h3D);
    shift_word(8'h81, 8'h3D, 8, "abort_next");
    ss_end();
    checks += 2;
    if (rx_data_o !== 8'h81) begin errors++; $display("FAIL abort_next_rx: got %h expected 81", rx_data_o); end
    if (rx_cnt - n0 != 1)    begin errors++; $display("FAIL abort_next_pulses: got %0d expected 1", rx_cnt - n0); end
  endtask

  task automatic test_reset_midframe();
    int n0;
    ss_begin(1'b0, 1'b0, 8'hC6);
    shift_word(8'h55, 8'hC6, 3, "rstmid");
    mosi_i = 1'b1;
    clks(HALF);
    sck_i = 1'b1;
    clks(HALF - 2);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy_o); end
    #2 rst_ni = 1'b0;
    #1;
    last_rx = 8'h00;
    checks += 4;
    if (miso_o !== 1'b0)     begin errors++; $display("FAIL rstmid_miso: got %b expected 0", miso_o); end
    if (rx_data_o !== 8'h00) begin errors++; $display("FAIL rstmid_rx_data: got %h expected 00", rx_data_o); end
    if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_rx_valid: got %b expected 0", rx_valid_o); end
    if (busy_o !== 1'b0)     begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy_o); end
    #99 rst_ni = 1'b1;
    sck_i = 1'b0;
    clks(4);
    n0 = rx_cnt;
    ss_begin(1'b0, 1'b0, 8'h96);
    shift_word(8'hFF, 8'h96, 8, "rstmid_next");
    ss_end();
    checks += 2;
    if (rx_data_o !== 8'hFF) begin errors++; $display("FAIL rstmid_next_rx: got %h expected ff", rx_data_o); end
    if (rx_cnt - n0 != 1)    begin errors++; $display("FAIL rstmid_next_pulses: got %0d expected 1", rx_cnt - n0); end
  endtask

  task automatic test_idle_sck();
    int n0;
    n0     = rx_cnt;
    ss_i   = 1'b1;
    ckp_i  = 1'b0;
    cph_i  = 1'b0;
    sck_i  = 1'b0;
    for (int i = 0; i < 18; i++) begin
      sck_i  = ~sck_i;
      mosi_i = i[0];
      clks(5);
      if (i % 6 == 5) begin
        checks += 2;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy[%0d]: got %b expected 0", i, busy_o); end
        if (miso_o !== 1'b0) begin errors++; $display("FAIL idle_miso[%0d]: got %b expected 0", i, miso_o); end
      end
    end
    clks(HALF);
    checks += 2;
    if (rx_cnt != n0)          begin errors++; $display("FAIL idle_pulses: got %0d expected 0", rx_cnt - n0); end
    if (rx_data_o !== last_rx) begin errors++; $display("FAIL idle_rx_data: got %h expected %h", rx_data_o, last_rx); end
  endtask

  initial begin
    test_reset();
    test_mode00();
    test_mode11();
    test_back_to_back();
    test_abort();
    test_reset_midframe();
    test_idle_sck();
    clks(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_pending: got %0d words left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
